// File: rtl/cache_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_ctrl_if
// Brief    : CPU request, memory request/return and cache update signals of
//            the cache fill controller, bundled with master (controller) and
//            slave (CPU/memory/cache environment) views.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_fill_ctrl_if;
  // CPU side
  logic        req_rd;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        miss;
  logic        stall;
  // Memory side
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  // Cache array update side
  logic [15:0] cache_addr;
  logic [15:0] cache_wdata;
  logic        datawrite;
  logic        metawrite;

  modport master (
    input  req_rd, req_wr, req_addr, req_wdata, miss, mem_rvalid, mem_rdata,
    output stall, mem_en, mem_wr, mem_addr, mem_wdata,
    output cache_addr, cache_wdata, datawrite, metawrite
  );

  modport slave (
    output req_rd, req_wr, req_addr, req_wdata, miss, mem_rvalid, mem_rdata,
    input  stall, mem_en, mem_wr, mem_addr, mem_wdata,
    input  cache_addr, cache_wdata, datawrite, metawrite
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_ctrl
// Brief    : Cache miss/store controller. Read misses fill a whole 8-word
//            block from memory (pipelined reads, returns written into the data
//            array as they arrive, tag written last). Stores are write-through,
//            no-allocate: one memory write, plus a data-array write on a hit.
// Options  : CACHE_FILL_CRITICAL_FIRST_EN - fill starts at the requested word,
//            wraps within the block, and releases the CPU right after the
//            critical word has been written.
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_ctrl #(
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_fill_ctrl_if.master bus
);

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  localparam bit c_CRIT = 1'b1;
`else
  localparam bit c_CRIT = 1'b0;
`endif

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_META  = 2'd2;
  localparam logic [1:0] c_WRITE = 2'd3;

  localparam logic [2:0] c_LAST_WORD = 3'(BLK_WORDS - 1);

  // The word offset is hard-wired to address[3:1]; reject other geometries.
  if (BLK_WORDS != 8 || MEM_LAT < 1) begin : g_bad_cfg
    $error("cache_fill_ctrl: BLK_WORDS must be 8 and MEM_LAT at least 1");
  end

  logic [1:0]  r_state;
  logic [15:0] r_base;        // block base address, low nibble always zero
  logic [2:0]  r_start;       // first word of the fill (0 unless critical-first)
  logic [2:0]  r_issue_cnt;   // index of the read being issued this cycle
  logic        r_issue_done;  // all reads of the block issued
  logic [2:0]  r_ret_cnt;     // index of the next expected return
  logic [15:0] r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_hit;
  logic        r_done;        // request just finished: release the CPU once
  logic        r_crit_done;   // critical word has been written
  logic        r_crit_rel;    // release cycle for the critical word is over

  logic [2:0]  w_req_word;
  logic [2:0]  w_issue_word;
  logic [2:0]  w_ret_word;
  logic        w_fill_stall;

  assign w_req_word   = c_CRIT ? bus.req_addr[3:1] : 3'd0;
  assign w_issue_word = r_start + r_issue_cnt;
  assign w_ret_word   = r_start + r_ret_cnt;

  // Stall during FILL/META: always in the plain build; early restart otherwise.
  always_comb begin
    w_fill_stall = 1'b1;
    if (c_CRIT && r_crit_done) begin
      if (!r_crit_rel) begin
        w_fill_stall = 1'b0;
      end else begin
        w_fill_stall = bus.req_rd || bus.req_wr;
      end
    end
  end

  // State, counters and captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_base       <= 16'h0000;
      r_start      <= 3'd0;
      r_issue_cnt  <= 3'd0;
      r_issue_done <= 1'b0;
      r_ret_cnt    <= 3'd0;
      r_wr_addr    <= 16'h0000;
      r_wr_data    <= 16'h0000;
      r_wr_hit     <= 1'b0;
      r_done       <= 1'b0;
      r_crit_done  <= 1'b0;
      r_crit_rel   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_done <= 1'b0;
          // The request that just completed is still visible this cycle.
          if (!r_done) begin
            if (bus.req_wr) begin
              r_state   <= c_WRITE;
              r_wr_addr <= bus.req_addr;
              r_wr_data <= bus.req_wdata;
              r_wr_hit  <= !bus.miss;
            end else if (bus.req_rd && bus.miss) begin
              // Word 0 of the fill is issued in this cycle already.
              r_state      <= c_FILL;
              r_base       <= {bus.req_addr[15:4], 4'h0};
              r_start      <= w_req_word;
              r_issue_cnt  <= 3'd1;
              r_issue_done <= 1'b0;
              r_ret_cnt    <= 3'd0;
              r_crit_done  <= 1'b0;
              r_crit_rel   <= 1'b0;
            end
          end
        end
        c_FILL: begin
          if (!r_issue_done) begin
            if (r_issue_cnt == c_LAST_WORD) begin
              r_issue_done <= 1'b1;
            end else begin
              r_issue_cnt <= r_issue_cnt + 3'd1;
            end
          end
          if (bus.mem_rvalid) begin
            if (r_ret_cnt == 3'd0) begin
              r_crit_done <= 1'b1;
            end
            if (r_ret_cnt == c_LAST_WORD) begin
              r_state <= c_META;
            end else begin
              r_ret_cnt <= r_ret_cnt + 3'd1;
            end
          end
          if (r_crit_done) begin
            r_crit_rel <= 1'b1;
          end
        end
        c_META: begin
          r_state <= c_IDLE;
          // With early restart the original request finished long ago.
          r_done  <= !c_CRIT;
        end
        default: begin
          r_state <= c_IDLE;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  // Output decode from state, counters and (in IDLE/FILL) live inputs.
  always_comb begin
    bus.stall       = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = 16'h0000;
    bus.mem_wdata   = 16'h0000;
    bus.cache_addr  = 16'h0000;
    bus.cache_wdata = 16'h0000;
    bus.datawrite   = 1'b0;
    bus.metawrite   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (rst_n && !r_done) begin
          if (bus.req_wr) begin
            bus.stall = 1'b1;
          end else if (bus.req_rd && bus.miss) begin
            bus.stall    = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_addr = {bus.req_addr[15:4], w_req_word, 1'b0};
          end
        end
      end
      c_FILL: begin
        bus.stall = w_fill_stall;
        if (!r_issue_done) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = {r_base[15:4], w_issue_word, 1'b0};
        end
        if (bus.mem_rvalid) begin
          bus.datawrite   = 1'b1;
          bus.cache_addr  = {r_base[15:4], w_ret_word, 1'b0};
          bus.cache_wdata = bus.mem_rdata;
        end
      end
      c_META: begin
        bus.stall      = w_fill_stall;
        bus.metawrite  = 1'b1;
        bus.cache_addr = r_base;
      end
      default: begin
        bus.stall     = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = r_wr_addr;
        bus.mem_wdata = r_wr_data;
        if (r_wr_hit) begin
          bus.datawrite   = 1'b1;
          bus.cache_addr  = r_wr_addr;
          bus.cache_wdata = r_wr_data;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4, cycles from mem_en (read) to the matching mem_rvalid.
REQ-002 SHALL have parameter BLK_WORDS, default 8, 16-bit words per cache block (fixed 8; offset field is address[3:1]).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_rd / req_wr  input  1 each  CPU read / write request, held until stall low.
REQ-006 SHALL have port req_addr  input  16  CPU byte address {tag[15:10], set[9:4], word[3:1], 0}.
REQ-007 SHALL have port req_wdata  input  16  CPU store data.
REQ-008 SHALL have port miss  input  1  active-high tag miss from the cache for req_addr.
REQ-009 SHALL have port stall  output  1  freeze the CPU pipeline.
REQ-010 SHALL have ports mem_en, mem_wr  output  1 each; mem_addr  output  16; mem_wdata  output  16: memory request.
REQ-011 SHALL have ports mem_rvalid  input  1; mem_rdata  input  16: read return, in issue order.
REQ-012 SHALL have ports cache_addr  output  16; cache_wdata  output  16; datawrite, metawrite  output  1 each: cache fill/update.

Function
REQ-013 SHALL implement states IDLE, FILL, META, WRITE.
REQ-014 IDLE: req_rd & miss -> FILL; req_wr (hit or miss) -> WRITE; else stay. req_rd & req_wr together SHALL be treated as write.
REQ-015 stall SHALL be combinationally high in IDLE whenever (req_rd & miss) or req_wr, and high in every non-IDLE state.
REQ-016 FILL SHALL latch base = {req_addr[15:4], 4'b0} on entry and issue BLK_WORDS reads on consecutive cycles, one per cycle, mem_addr = base + 2*issue_cnt, mem_en=1, mem_wr=0.
REQ-017 Each mem_rvalid in FILL SHALL assert datawrite same cycle with cache_addr = base + 2*ret_cnt, cache_wdata = mem_rdata; ret_cnt increments.
REQ-018 mem_rvalid in IDLE, META or WRITE SHALL be ignored (no datawrite).
REQ-019 After the 8th return FILL -> META; META asserts metawrite for exactly one cycle with cache_addr = base, then -> IDLE.
REQ-020 Read-miss total stall SHALL be 1 + (BLK_WORDS-1) + MEM_LAT + 1 cycles = 13 with defaults.
REQ-021 WRITE (write-through, no-allocate): one cycle, mem_en=1, mem_wr=1, mem_addr=req_addr, mem_wdata=req_wdata; datawrite=1 with cache_addr=req_addr, cache_wdata=req_wdata only if miss=0 (hit); -> IDLE.
REQ-022 issue_cnt and ret_cnt SHALL be 3-bit, stop at 7/8 completion, no wrap into a second block.
REQ-023 miss and req_addr SHALL be sampled only in IDLE; changes during FILL/META have no effect.
REQ-024 datawrite and metawrite SHALL never be high outside FILL/META/WRITE; metawrite never with datawrite.

Reset
REQ-025 rst low SHALL immediately force IDLE, counters 0, base 0, and stall, mem_en, mem_wr, datawrite, metawrite 0; mem_addr, mem_wdata, cache_addr, cache_wdata 0.
REQ-026 rst asserted mid-FILL SHALL abandon the fill without metawrite; after release, in-flight mem_rvalid pulses are ignored.

Configuration
REQ-027 Macro CACHE_FILL_CRITICAL_FIRST_EN defined: FILL issues and writes words starting at req_addr[3:1], wrapping modulo 8 (word k = (start+k) mod 8); stall deasserts the cycle after the critical word's datawrite while the remaining fill continues; a new req_rd/req_wr during the remaining fill waits (stall high) until return to IDLE.
REQ-028 Macro undefined: word order 0..7 from base and stall per REQ-020.

Verification
REQ-029 Read miss req_addr=16'h1A36, MEM_LAT=4 -> reads 16'h1A30..16'h1A3E, 8 datawrites in order, one metawrite cache_addr=16'h1A30, stall high 13 cycles.
REQ-030 Read hit (miss=0) req_rd -> stall 0, no mem_en, no datawrite.
REQ-031 Write miss req_addr=16'h0402, wdata=16'hBEEF -> one cycle mem_en=mem_wr=1, mem_addr=16'h0402, no datawrite, no metawrite; write hit same -> additional datawrite 16'hBEEF.
REQ-032 rst low after 3rd return of a fill -> all outputs 0 immediately; remaining 5 mem_rvalid after release produce no datawrite/metawrite.
REQ-033 With CACHE_FILL_CRITICAL_FIRST_EN, req_addr=16'h003C -> fill order 16'h003C,003E,0030..003A; stall drops the cycle after the 003C datawrite.
REQ-034 req_rd and req_wr both high with miss=1 -> WRITE path only, no FILL.
